// File: rtl/ef_lfsr_pkg.sv
// Shared constants and the single-step Fibonacci LFSR function for the
// ef_lfsr_par generator (trinomial 1 + x^T + x^N).
package ef_lfsr_pkg;

  // Widest register the step function handles.
  localparam int LFSR_MAX_N = 32;

  // Default geometry: 20-bit register, tap at x^3, 8 states per clock.
  localparam int LFSR_N_DEF = 20;
  localparam int LFSR_T_DEF = 3;
  localparam int LFSR_K_DEF = 8;

  // State the register holds after reset; returning to it marks a wrap.
  localparam logic [LFSR_MAX_N-1:0] LFSR_RESET_SEED = 32'h0000_0001;

  // One Fibonacci step on an n-bit state held in the low bits of q:
  // shift right by one, feed q[0]^q[t] into bit n-1. Bits at or above n
  // must be zero on entry and stay zero on exit.
  function automatic logic [LFSR_MAX_N-1:0] lfsr_step(
    input logic [LFSR_MAX_N-1:0] q,
    input int unsigned           n,
    input int unsigned           t
  );
    logic [LFSR_MAX_N-1:0] r;
    int unsigned           hi;
    hi            = n - 1;
    r             = q >> 1;
    r[hi[4:0]]    = q[0] ^ q[t[4:0]];
    return r;
  endfunction

endpackage

// File: rtl/ef_lfsr_par_jump.sv
// Combinational K-step advance of the LFSR state. Kept as its own module
// so the jump network can be equivalence-checked in isolation.
module ef_lfsr_par_jump
  import ef_lfsr_pkg::*;
#(
  parameter int N = LFSR_N_DEF,
  parameter int T = LFSR_T_DEF,
  parameter int K = LFSR_K_DEF
) (
  input  logic [N-1:0] q,
  output logic [N-1:0] q_next
);

  logic [LFSR_MAX_N-1:0] acc;

  // Compose the single step K times. With K < N every output bit is a
  // shallow XOR of a few state bits, so depth stays small even at K=16.
  always_comb begin
    acc        = '0;
    acc[N-1:0] = q;
    for (int k = 0; k < K; k++) begin
      acc = lfsr_step(acc, N, T);
    end
    q_next = acc[N-1:0];
  end

endmodule

// File: rtl/ef_lfsr_par.sv
// Multi-tap Fibonacci LFSR advancing K states per enabled clock, with
// run-time seed load, all-zero lock-up recovery (sticky fault flag) and a
// registered wrap pulse when an advance lands back on the reset seed.
// Control: i_load wins over i_en; both are level qualifiers sampled on the
// rising edge of i_clk, there is no backpressure.
module ef_lfsr_par
  import ef_lfsr_pkg::*;
#(
  parameter int N = LFSR_N_DEF,
  parameter int T = LFSR_T_DEF,
  parameter int K = LFSR_K_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_b,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [N-1:0] i_seed,
  output logic [K-1:0] o_r,
  output logic         o_wrap,
  output logic         o_fault
);

  // Reject geometries the step function or output slice cannot support.
  generate
    if (N < 3 || N > LFSR_MAX_N) begin : g_bad_n
      $error("ef_lfsr_par: N must be in 3..32");
    end
    if (T < 1 || T > N - 1) begin : g_bad_t
      $error("ef_lfsr_par: T must be in 1..N-1");
    end
    if (K < 1 || K > N - 1) begin : g_bad_k
      $error("ef_lfsr_par: K must be in 1..N-1");
    end
  endgenerate

  localparam logic [N-1:0] SEED = LFSR_RESET_SEED[N-1:0];

  logic [N-1:0] q;
  logic [N-1:0] q_jump;
  logic         wrap;
  logic         fault;

  ef_lfsr_par_jump #(
    .N(N),
    .T(T),
    .K(K)
  ) u_jump (
    .q      (q),
    .q_next (q_jump)
  );

  // State register with load > recover-from-zero > advance > hold priority;
  // wrap and fault update on the same edge as the state change causing them.
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      q     <= SEED;
      wrap  <= 1'b0;
      fault <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (i_load) begin
        if (i_seed != '0) begin
          q     <= i_seed;
          fault <= 1'b0;
        end else begin
          q     <= SEED;
          fault <= 1'b1;
        end
      end else if (i_en) begin
        if (q == '0) begin
          q     <= SEED;
          fault <= 1'b1;
        end else begin
          q    <= q_jump;
          wrap <= (q_jump == SEED);
        end
      end
    end
  end

  // Bit 0 is never exposed; the K output bits come straight off the register.
  assign o_r     = q[K:1];
  assign o_wrap  = wrap;
  assign o_fault = fault;

endmodule

// File: tb/tb_ef_lfsr_par.sv
// Bench for ef_lfsr_par: three instances (default 20/3/8, 7/1/3, 32/10/16),
// driver tasks push expected {state, wrap, fault} into per-instance queues,
// monitors pop and compare one sample after each driven edge.
module tb_ef_lfsr_par;

  localparam int NA = 20, TA = 3,  KA = 8;
  localparam int NB = 7,  TB = 1,  KB = 3;
  localparam int NC = 32, TC = 10, KC = 16;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // Instance A (defaults)
  logic          en_a   = 1'b0;
  logic          load_a = 1'b0;
  logic [NA-1:0] seed_a = '0;
  logic [KA-1:0] r_a;
  logic          wrap_a, fault_a;

  // Instances B and C share enable; never loaded
  logic          en_bc   = 1'b0;
  logic          load_bc = 1'b0;
  logic [NB-1:0] seed_b  = '0;
  logic [NC-1:0] seed_c  = '0;
  logic [KB-1:0] r_b;
  logic [KC-1:0] r_c;
  logic          wrap_b, fault_b, wrap_c, fault_c;

  ef_lfsr_par #(.N(NA), .T(TA), .K(KA)) dut_a (
    .i_clk(clk), .i_rst_b(rst_b), .i_en(en_a), .i_load(load_a), .i_seed(seed_a),
    .o_r(r_a), .o_wrap(wrap_a), .o_fault(fault_a));

  ef_lfsr_par #(.N(NB), .T(TB), .K(KB)) dut_b (
    .i_clk(clk), .i_rst_b(rst_b), .i_en(en_bc), .i_load(load_bc), .i_seed(seed_b),
    .o_r(r_b), .o_wrap(wrap_b), .o_fault(fault_b));

  ef_lfsr_par #(.N(NC), .T(TC), .K(KC)) dut_c (
    .i_clk(clk), .i_rst_b(rst_b), .i_en(en_bc), .i_load(load_bc), .i_seed(seed_c),
    .o_r(r_c), .o_wrap(wrap_c), .o_fault(fault_c));

  // Scoreboard state
  logic [NA+1:0] exp_a[$];
  logic [NB+1:0] exp_b[$];
  logic [NC+1:0] exp_c[$];
  int errors = 0;
  int checks = 0;
  int b_wraps = 0;

  // Golden model state
  logic [NA-1:0] m_a = 1;
  logic          m_af = 1'b0, m_aw = 1'b0;
  logic [NB-1:0] m_b = 1;
  logic [NC-1:0] m_c = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference: one step at a time, K steps per advance.
  function automatic logic [31:0] gstep(input logic [31:0] q, input int n, input int t);
    logic [31:0] tap;
    logic        fb;
    tap = q >> t;
    fb  = q[0] ^ tap[0];
    return (q >> 1) | (32'(fb) << (n - 1));
  endfunction

  function automatic logic [31:0] gadv(input logic [31:0] q, input int n, input int t, input int k);
    logic [31:0] s;
    s = q;
    for (int i = 0; i < k; i++) s = gstep(s, n, t);
    return s;
  endfunction

  // Driver: one cycle on instance A, expected value from the model.
  task automatic step_a(input logic en, input logic ld, input logic [NA-1:0] sd);
    @(negedge clk);
    en_a = en; load_a = ld; seed_a = sd;
    if (ld) begin
      m_aw = 1'b0;
      if (sd != '0) begin m_a = sd; m_af = 1'b0; end
      else begin m_a = 1; m_af = 1'b1; end
    end else if (en && m_a == '0) begin
      m_a = 1; m_af = 1'b1; m_aw = 1'b0;
    end else if (en) begin
      m_a  = NA'(gadv(32'(m_a), NA, TA, KA));
      m_aw = (m_a == 1);
    end else begin
      m_aw = 1'b0;
    end
    exp_a.push_back({m_a, m_aw, m_af});
    @(posedge clk); #1;
    en_a = 1'b0; load_a = 1'b0;
  endtask

  // Driver: one cycle on instance A with a hand-computed expected result.
  task automatic hand_a(input logic en, input logic ld, input logic [NA-1:0] sd,
                        input logic [NA-1:0] hq, input logic hw, input logic hf);
    @(negedge clk);
    en_a = en; load_a = ld; seed_a = sd;
    m_a = hq; m_aw = hw; m_af = hf;
    exp_a.push_back({hq, hw, hf});
    @(posedge clk); #1;
    en_a = 1'b0; load_a = 1'b0;
  endtask

  // Driver: one cycle on instances B and C.
  task automatic step_bc(input logic en);
    logic wb, wc;
    @(negedge clk);
    en_bc = en;
    wb = 1'b0; wc = 1'b0;
    if (en) begin
      m_b = NB'(gadv(32'(m_b), NB, TB, KB));
      m_c = NC'(gadv(32'(m_c), NC, TC, KC));
      wb  = (m_b == 1);
      wc  = (m_c == 1);
    end
    exp_b.push_back({m_b, wb, 1'b0});
    exp_c.push_back({m_c, wc, 1'b0});
    @(posedge clk); #1;
    en_bc = 1'b0;
  endtask

  // Monitor: compare the registered outputs just after each edge.
  always @(posedge clk) begin
    logic [NA+1:0] ea;
    logic [NB+1:0] eb;
    logic [NC+1:0] ec;
    #1;
    if (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      check("a_state", 64'(dut_a.q), 64'(ea[NA+1:2]));
      check("a_r",     64'(r_a),     64'(ea[KA+2:3]));
      check("a_wrap",  64'(wrap_a),  64'(ea[1]));
      check("a_fault", 64'(fault_a), 64'(ea[0]));
    end
    if (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      if (wrap_b) b_wraps++;
      check("b_r",     64'(r_b),     64'(eb[KB+2:3]));
      check("b_wrap",  64'(wrap_b),  64'(eb[1]));
      check("b_fault", 64'(fault_b), 64'(eb[0]));
    end
    if (exp_c.size() > 0) begin
      ec = exp_c.pop_front();
      check("c_r",     64'(r_c),     64'(ec[KC+2:3]));
      check("c_wrap",  64'(wrap_c),  64'(ec[1]));
      check("c_fault", 64'(fault_c), 64'(ec[0]));
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stimulus
  initial begin
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_r",     64'(r_a),     64'h0);
    check("rst_a_wrap",  64'(wrap_a),  64'h0);
    check("rst_a_fault", 64'(fault_a), 64'h0);
    check("rst_a_state", 64'(dut_a.q), 64'h1);
    @(negedge clk);
    rst_b = 1'b1;

    // First two advances from the reset seed
    hand_a(1, 0, '0, 20'h01000, 0, 0);
    hand_a(1, 0, '0, 20'h00010, 0, 0);
    check("a_r_second", 64'(r_a), 64'h08);

    // Load beats enable; then model-checked advances from the seed
    hand_a(1, 1, 20'hABCDE, 20'hABCDE, 0, 0);
    repeat (20) step_a(1, 0, '0);

    // Zero seed: recover to 1, fault sticks over 100 advances, cleared by load
    hand_a(0, 1, 20'h00000, 20'h00001, 0, 1);
    repeat (100) step_a(1, 0, '0);
    hand_a(0, 1, 20'h00005, 20'h00005, 0, 0);
    repeat (3) step_a(0, 0, '0);

    // Loading the reset seed itself does not pulse wrap
    hand_a(1, 1, 20'h00001, 20'h00001, 0, 0);

    // Predecessor of the seed: the advance landing on 1 pulses wrap once
    hand_a(0, 1, 20'h00124, 20'h00124, 0, 0);
    hand_a(1, 0, '0, 20'h00001, 1, 0);
    hand_a(1, 0, '0, 20'h01000, 0, 0);

    // Backdoor all-zero state, then enable: recover with fault, no wrap
    @(negedge clk);
    force dut_a.q = '0;
    #1;
    release dut_a.q;
    hand_a(1, 0, '0, 20'h00001, 0, 1);

    // Mixed enables with occasional random loads
    for (int i = 0; i < 1500; i++) begin
      step_a(1'($urandom_range(0, 1)), (i % 300) == 299, NA'($urandom));
    end

    // Small instance: 127 advances return to the seed exactly once
    repeat (127) step_bc(1);
    @(negedge clk);
    check("b_wrap_count", 64'(b_wraps), 64'd1);
    for (int i = 0; i < 200; i++) step_bc(1'($urandom_range(0, 1)));

    // Asynchronous reset mid-run with the fault flag set
    hand_a(0, 1, 20'h00000, 20'h00001, 0, 1);
    repeat (5) step_a(1, 0, '0);
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("midrst_a_r",     64'(r_a),     64'h0);
    check("midrst_a_wrap",  64'(wrap_a),  64'h0);
    check("midrst_a_fault", 64'(fault_a), 64'h0);
    check("midrst_b_r",     64'(r_b),     64'h0);
    check("midrst_c_r",     64'(r_c),     64'h0);
    check("midrst_c_fault", 64'(fault_c), 64'h0);
    @(negedge clk);
    rst_b = 1'b1;
    m_a = 1; m_af = 1'b0; m_b = 1; m_c = 1;
    hand_a(1, 0, '0, 20'h01000, 0, 0);
    step_bc(1);

    // Drain and report
    @(negedge clk);
    @(negedge clk);
    check("drain_a", 64'(exp_a.size()), 64'd0);
    check("drain_bc", 64'(exp_b.size() + exp_c.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ef_lfsr_par.md
# ef_lfsr_par

Parametrised multi-tap Fibonacci LFSR for the DAC mismatch-shaping and dither path. It implements a trinomial 1 + x^T + x^N and advances K states per enabled clock, so the K tapped output bits are uncorrelated. It adds features the fixed 20/8 generator lacks: run-time seed load, all-zero lock-up protection with a fault flag, and a wrap pulse when the state returns to the reset seed.

## Interface
- N, 20, register length in bits; legal 3..32
- T, 3, inner tap exponent; legal 1..N-1
- K, 8, states advanced per enabled clock and output width; legal 1..N-1
- i_clk  in  1  clock
- i_rst_b  in  1  reset, asynchronous, active-low; clock i_clk
- i_en  in  1  advance K states this cycle
- i_load  in  1  load i_seed into state this cycle; has priority over i_en
- i_seed  in  N  seed value, sampled only when i_load=1
- o_r  out  K  random bits, equal to q[K:1]
- o_wrap  out  1  one-cycle pulse: last advance landed on state 1
- o_fault  out  1  sticky: zero seed was loaded or all-zero state was detected

## Operation
- State q[N-1:0]. Single step: q'[N-1] = q[0]^q[T]; q'[i] = q[i+1] for i < N-1. One advance is the single step composed K times, evaluated combinationally within one clock.
- Reset: q = 1 (only bit 0 set), o_wrap = 0, o_fault = 0. As a result o_r = 0.
- Per-cycle priority:
  - If i_load=1 and i_seed != 0: q = i_seed, o_fault cleared.
  - If i_load=1 and i_seed == 0: q = 1, o_fault set.
  - Else if i_en=1 and q == 0 (defensive; only reachable by upset): q = 1, o_fault set, o_wrap = 0.
  - Else if i_en=1: q = advance(q).
  - Else: hold q.
- o_wrap is registered. It is 1 in the cycle after an i_en advance produced q == 1, otherwise 0. A load of value 1 does not pulse o_wrap.
- o_fault clears only on reset or on a load of a nonzero seed.
- No arithmetic; all operations are XOR and shift. The width of o_r is exactly K, taken from bits K..1. Bit 0 is never output.

## Timing
- Latency from an advance or load to o_r is 1 cycle. o_r is a direct slice of the state register, with no extra pipeline stage.
- o_wrap and o_fault are registered and change in the same edge as the q update that causes them.
- i_load and i_en asserted together: the load wins, there is no advance that cycle, and o_wrap = 0.
- i_en held high: one advance per cycle, no bubbles.
- Async reset mid-run: all outputs go to their reset values immediately. The first advance after release begins from q = 1.
- The combinational depth of advance grows with K. The implementation must meet timing at N=32, K=16.

## Structure
- ef_lfsr_pkg holds:
  - default N/T/K localparams;
  - the reset seed constant (1);
  - function lfsr_step(q, N, T).
- Sub-module ef_lfsr_jump is a combinational K-step advance (for-loop over lfsr_step) instantiated once. Keeping it separate allows a formal equivalence check of the jump logic.
- The top level holds only the state register, the priority mux, and the wrap/fault flags.
- Elaboration-time assertions reject illegal N, T, or K.

## Test plan
- Defaults, reset release, one i_en pulse: q 0x00001 -> 0x01000, o_r stays 0x00. A second pulse gives q = 0x00010 and o_r = 0x08.
- Defaults, i_en held for 2^20-1 advances from reset: o_wrap pulses exactly once, on the final advance (gcd(K, period)=1). q never equals 0. The result must match a bit-serial golden model stepped 8x.
- Load i_seed=0xABCDE with i_en=1 in the same cycle: next q = 0xABCDE with no advance and o_fault = 0. The next advance must match the golden model.
- Load i_seed=0: q = 0x00001 and o_fault = 1. o_fault stays set across 100 advances, then clears when 0x00005 is loaded.
- Force q to 0 via a bench backdoor, then pulse i_en: q = 0x00001, o_fault = 1, o_wrap = 0.
- Parameter sweep N=7/T=1/K=3 and N=32/T=10/K=16: per-advance match to the golden model over 10k cycles. Assert i_rst_b mid-run: o_r = 0, o_wrap = 0, o_fault = 0 immediately.
